cla_serial_add_ctrl: RTL and testbench
======================================

Name: cla_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by reusing one 8-bit carry-lookahead adder (add_8_bit) over WIDTH/8 consecutive cycles, least-significant byte first. It latches operands on a start handshake, iterates a byte counter, ripples the carry through a register between bytes, and reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-saving alternative to a full-width lookahead adder in the arithmetic unit.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8.
NBYTES, WIDTH/8, derived byte count; not overridden independently.
CW, clog2(NBYTES) with minimum 1, byte-index counter width; derived.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; accepted only on a cycle where ready=1.
sub  input  1  1 = a - b, 0 = a + b + c_in; sampled with start.
c_in  input  1  carry-in for add; ignored when sub=1.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
ready  output  1  high only in IDLE.
done  output  1  one-cycle pulse; results valid.
s  output  WIDTH  result.
c_out  output  1  carry out of the MSB (for sub: 1 = no borrow, i.e. a >= b unsigned).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is synchronous and active-high. Reset values: state IDLE, ready=1, done=0, s=0, c_out=0, ovf=0, byte index=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. When start=1: latch A=a, B=(sub ? ~b : b), carry=(sub ? 1 : c_in), idx=0, clear s; go to RUN.
- RUN: ready=0. Each cycle, adder inputs are A[idx*8+:8], B[idx*8+:8] and the carry register.
  - Byte carry = g_out | (p_out & carry). Write the sum byte into s[idx*8+:8] and update the carry register.
  - If idx==NBYTES-1: c_out <= byte carry, ovf <= (A[MSB]==B[MSB]) && (sum MSB != A[MSB]), go to DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, ready=0; then go to IDLE.
- Latency: start sampled at edge E0. RUN occupies cycles 1..NBYTES after E0. done is high in cycle NBYTES+1, and ready returns high in cycle NBYTES+2.
- Outputs hold their values after done until the next accepted start. s is cleared at acceptance, so partial bytes are visible during RUN; consumers use done only.
- start while ready=0, including during DONE, is ignored and not queued. Operands and sub changing during RUN have no effect.
- Reset mid-operation aborts immediately: no done pulse, all registers take reset values.
- Carry propagates across byte boundaries only through the carry register, never combinationally across cycles.
- NBYTES=1: RUN lasts one cycle; done in cycle 2 after acceptance.
- Index counter never exceeds NBYTES-1 and does not wrap.

Test Plan:
- WIDTH=32, add a=0xFFFFFFFF, b=0x00000001, c_in=0 -> s=0x00000000, c_out=1, ovf=0, done exactly 5 cycles after start edge, ready high the following cycle.
- Sub a=5, b=7 -> s=0xFFFFFFFE, c_out=0, ovf=0; sub a=7, b=5 -> s=0x00000002, c_out=1, ovf=0.
- Add a=0x7FFFFFFF, b=1 -> s=0x80000000, ovf=1, c_out=0; sub a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1, c_out=1.
- Add a=0x000000FF, b=0, c_in=1 -> s=0x00000100, carry crosses byte 0 to byte 1; c_in=1 with sub=1, a=3, b=3 -> s=0 (c_in ignored).
- start pulsed every cycle during RUN/DONE with differing operands -> only first operation executes, one done pulse; assert rst in cycle 2 of RUN -> no done, ready=1 and s=0 the cycle after reset.
- WIDTH=8 build: a=0x80, b=0x80 add -> s=0x00, c_out=1, ovf=1, done in cycle 2 after acceptance.

Source files
------------

// File: rtl/cla_serial_add_ctrl.sv
// Serial WIDTH-bit adder/subtractor built around one 8-bit carry-lookahead
// adder. Operands are latched on start and walked least-significant byte
// first, one byte per cycle, with the inter-byte carry held in a register.

// 8-bit carry-lookahead adder with group generate/propagate outputs.
module add_8_bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  output logic [7:0] o_sum,
  output logic       o_g,
  output logic       o_p
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [7:0] w_c;
  logic       w_gg;

  assign w_g   = i_a & i_b;
  assign w_p   = i_a ^ i_b;
  assign o_sum = w_p ^ w_c;
  assign o_g   = w_gg;
  assign o_p   = &w_p;

  // Every bit carry and the group generate are flattened sums of g/p products.
  always_comb begin
    logic v_t;
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it holding an old value (no latch).
    w_c  = '0;
    w_gg = 1'b0;
    v_t  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v_t = i_c;
      for (int j = 0; j < i; j++) begin
        v_t = w_g[j] | (w_p[j] & v_t);
      end
      w_c[i] = v_t;
    end
    for (int j = 0; j < 8; j++) begin
      w_gg = w_g[j] | (w_p[j] & w_gg);
    end
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_idx;
  logic             r_carry;
  logic             r_ready;
  logic             r_done;
  logic             r_c_out;
  logic             r_ovf;

  logic [CW+2:0]    w_shift;
  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic [7:0]       w_sum;
  logic             w_g;
  logic             w_p;
  logic             w_byte_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_s_next;

  // Bit offset of the current byte; shifts avoid out-of-range part-selects
  // when WIDTH is a single byte.
  assign w_shift  = {r_idx, 3'b000};
  assign w_a_byte = 8'(r_a >> w_shift);
  assign w_b_byte = 8'(r_b >> w_shift);
  assign w_last   = (r_idx == CW'(NBYTES - 1));

  add_8_bit u_add (
    .i_a   (w_a_byte),
    .i_b   (w_b_byte),
    .i_c   (r_carry),
    .o_sum (w_sum),
    .o_g   (w_g),
    .o_p   (w_p)
  );

  assign w_byte_carry = w_g | (w_p & r_carry);
  assign w_s_next     = (r_s & ~(WIDTH'(8'hFF) << w_shift))
                      | (WIDTH'(w_sum) << w_shift);

  assign ready = r_ready;
  assign done  = r_done;
  assign s     = r_s;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

  // Sequencer: accept in IDLE, one byte per RUN cycle, single-cycle DONE.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (rst) begin
      // NOTE: operand and result registers are reset too, so the datapath
      // holds known values after an aborted operation.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
            r_s     <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_s     <= w_s_next;
          r_carry <= w_byte_carry;
          if (w_last) begin
            r_c_out <= w_byte_carry;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[7] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, monitors compare them
// against each done pulse of a 32-bit and an 8-bit instance.
module tb_cla_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, sub, c_in;
  logic [31:0] a, b;
  logic        ready, done, c_out, ovf;
  logic [31:0] s;

  logic        start8, sub8, c_in8;
  logic [7:0]  a8, b8;
  logic        ready8, done8, c_out8, ovf8;
  logic [7:0]  s8;

  cla_serial_add_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .c_in(c_in),
    .a(a), .b(b), .ready(ready), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
  );

  cla_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .c_in(c_in8),
    .a(a8), .b(b8), .ready(ready8), .done(done8), .s(s8), .c_out(c_out8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        check("done32_unexpected", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("s32", s, e.s);
        check("c_out32", {31'b0, c_out}, {31'b0, e.c});
        check("ovf32", {31'b0, ovf}, {31'b0, e.v});
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", {31'b0, done8}, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("s8", {24'b0, s8}, e.s);
        check("c_out8", {31'b0, c_out8}, {31'b0, e.c});
        check("ovf8", {31'b0, ovf8}, {31'b0, e.v});
      end
    end
  end

  // One 32-bit operation; hammer keeps start high with changing operands.
  task automatic run32(input logic sb, input logic ci, input logic [31:0] aa,
                       input logic [31:0] bb, input exp_t e, input bit hammer);
    int k;
    @(negedge clk);
    check("ready_before_start", {31'b0, ready}, 32'd1);
    q32.push_back(e);
    start = 1'b1; sub = sb; c_in = ci; a = aa; b = bb;
    @(posedge clk);
    #1;
    if (!hammer) start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (hammer) begin
        a = a + 32'h0101_0101;
        b = ~b;
        sub = ~sub;
        c_in = ~c_in;
      end
    end while (done !== 1'b1 && k < 20);
    check("done_latency32", 32'(k), 32'd5);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ready_after_done32", {31'b0, ready}, 32'd1);
    check("done_one_cycle32", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; c_in8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_s", s, 32'd0);
    check("reset_c_out", {31'b0, c_out}, 32'd0);
    check("reset_ovf", {31'b0, ovf}, 32'd0);

    run32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0}, 1'b0);
    run32(1'b1, 1'b0, 32'd5,         32'd7,         '{32'hFFFF_FFFE, 1'b0, 1'b0}, 1'b0);
    run32(1'b1, 1'b0, 32'd7,         32'd5,         '{32'h0000_0002, 1'b1, 1'b0}, 1'b0);
    run32(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1}, 1'b0);
    run32(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b1, 1'b1}, 1'b0);
    run32(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0000, '{32'h0000_0100, 1'b0, 1'b0}, 1'b0);
    run32(1'b1, 1'b1, 32'd3,         32'd3,         '{32'h0000_0000, 1'b1, 1'b0}, 1'b0);
    run32(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, '{32'h2345_6789, 1'b0, 1'b0}, 1'b0);

    // start held high through RUN and DONE: only the first request executes.
    run32(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, '{32'h0000_0030, 1'b0, 1'b0}, 1'b1);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("no_extra_done", 32'(n_done), 32'd0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; c_in = 1'b0; a = 32'h1122_3344; b = 32'h0101_0101;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("partial_byte0", {24'b0, s[7:0]}, 32'h45);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_s", s, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    // Single-byte build: 0x80 + 0x80.
    begin
      int k;
      @(negedge clk);
      check("ready8_before_start", {31'b0, ready8}, 32'd1);
      q8.push_back('{32'h0000_0000, 1'b1, 1'b1});
      start8 = 1'b1; sub8 = 1'b0; c_in8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
      @(posedge clk);
      #1 start8 = 1'b0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (done8 !== 1'b1 && k < 20);
      check("done_latency8", 32'(k), 32'd2);
      @(negedge clk);
      check("ready_after_done8", {31'b0, ready8}, 32'd1);
    end

    repeat (2) @(negedge clk);
    check("q32_drained", 32'(q32.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
